// File: rtl/mem_copy_initiator.sv
// Bus-master block copy engine: reads a word from the source, writes it to the
// destination, and repeats over a single-port valid/ready memory interface.
module mem_copy_initiator #(
    parameter int unsigned LEN_W   = 13,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_done,
    output logic             mem_valid,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_wstrb,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata
);

    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [3:0]  WSTRB_WR = 4'hF;
    localparam logic [3:0]  WSTRB_RD = 4'h0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_GAP,
        S_WR,
        S_WR_GAP,
        S_FIN
    } state_e;

    state_e state_q, state_d;

    logic [31:0]      src_ptr_q, src_ptr_d;
    logic [31:0]      dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      data_q, data_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [LEN_W-1:0] words_done_q, words_done_d;
    logic             mem_valid_q, mem_valid_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [3:0]       mem_wstrb_q, mem_wstrb_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;

    logic rd_ack_c, wr_ack_c, tmo_hit_c, misaligned_c, len_zero_c;

    // Handshake qualifiers; ready only counts while a request is outstanding.
    always_comb begin
        rd_ack_c     = (state_q == S_RD) && mem_valid_q && mem_ready;
        wr_ack_c     = (state_q == S_WR) && mem_valid_q && mem_ready;
        tmo_hit_c    = mem_valid_q && !mem_ready && (tmo_q == TMO_W'(TIMEOUT - 1));
        misaligned_c = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
        len_zero_c   = (len_words == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && !misaligned_c && !len_zero_c) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (tmo_hit_c) begin
                    state_d = S_IDLE;
                end else if (rd_ack_c) begin
                    state_d = S_RD_GAP;
                end
            end
            S_RD_GAP: state_d = S_WR;
            S_WR: begin
                if (tmo_hit_c) begin
                    state_d = S_IDLE;
                end else if (wr_ack_c) begin
                    state_d = S_WR_GAP;
                end
            end
            S_WR_GAP: state_d = (words_done_q == len_q) ? S_FIN : S_RD;
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and registered bus outputs; each request launch clears the stall counter.
    always_comb begin
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        len_d        = len_q;
        data_d       = data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        words_done_d = words_done_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        tmo_d        = (mem_valid_q && !mem_ready) ? tmo_q + TMO_W'(1) : tmo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_ptr_d    = src_addr;
                    dst_ptr_d    = dst_addr;
                    len_d        = len_words;
                    words_done_d = '0;
                    if (misaligned_c) begin
                        err_d = 1'b1;
                    end else if (len_zero_c) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d      = 1'b1;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = src_addr;
                        mem_wstrb_d = WSTRB_RD;
                        tmo_d       = '0;
                    end
                end
            end
            S_RD: begin
                if (tmo_hit_c) begin
                    mem_valid_d = 1'b0;
                    err_d       = 1'b1;
                    busy_d      = 1'b0;
                end else if (rd_ack_c) begin
                    data_d      = mem_rdata;
                    mem_valid_d = 1'b0;
                end
            end
            S_RD_GAP: begin
                mem_valid_d = 1'b1;
                mem_addr_d  = dst_ptr_q;
                mem_wstrb_d = WSTRB_WR;
                mem_wdata_d = data_q;
                tmo_d       = '0;
            end
            S_WR: begin
                if (tmo_hit_c) begin
                    mem_valid_d = 1'b0;
                    err_d       = 1'b1;
                    busy_d      = 1'b0;
                end else if (wr_ack_c) begin
                    mem_valid_d  = 1'b0;
                    words_done_d = words_done_q + LEN_W'(1);
                    src_ptr_d    = src_ptr_q + 32'd4;
                    dst_ptr_d    = dst_ptr_q + 32'd4;
                end
            end
            S_WR_GAP: begin
                if (words_done_q != len_q) begin
                    mem_valid_d = 1'b1;
                    mem_addr_d  = src_ptr_q;
                    mem_wstrb_d = WSTRB_RD;
                    tmo_d       = '0;
                end
            end
            S_FIN: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: begin
                mem_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            len_q        <= '0;
            data_q       <= '0;
            tmo_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            words_done_q <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= '0;
            mem_wdata_q  <= '0;
        end else begin
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            len_q        <= len_d;
            data_q       <= data_d;
            tmo_q        <= tmo_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            words_done_q <= words_done_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign words_done = words_done_q;
    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_copy_initiator.sv
// Bench for mem_copy_initiator: randomized-latency memory responder, word-level
// copy model and per-cycle protocol checks.
module tb_mem_copy_initiator;

    localparam int unsigned LEN_W   = 13;
    localparam int unsigned TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len_words = '0;
    logic             busy, done, err;
    logic [LEN_W-1:0] words_done;
    logic             mem_valid;
    logic [31:0]      mem_addr;
    logic [3:0]       mem_wstrb;
    logic [31:0]      mem_wdata;
    logic             mem_ready = 1'b0;
    logic [31:0]      mem_rdata = '0;

    mem_copy_initiator #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
        .busy(busy), .done(done), .err(err), .words_done(words_done),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic [31:0] mem     [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];
    txn_t        obs_q[$];

    int stall_fixed = 0;
    bit rand_stall  = 1'b1;
    int hang_at     = 32'h7fff_ffff;
    int wait_cnt    = 0;
    int stall_cur   = 0;
    bit started     = 1'b0;

    // Responder: acts just after each rising edge, pulses ready for one cycle per request.
    always begin
        txn_t rec;
        @(posedge clk);
        #1;
        if (reset || !mem_valid) begin
            wait_cnt  = 0;
            started   = 1'b0;
            mem_ready = ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
        end else begin
            if (!started) begin
                stall_cur = rand_stall ? int'($urandom_range(0, 3)) : stall_fixed;
                started   = 1'b1;
                wait_cnt  = 0;
            end
            if (obs_q.size() >= hang_at || wait_cnt < stall_cur) begin
                wait_cnt++;
                mem_rdata = $urandom;
            end else begin
                mem_ready = 1'b1;
                started   = 1'b0;
                rec.wr    = (mem_wstrb != 4'h0);
                rec.strb  = mem_wstrb;
                rec.addr  = mem_addr;
                if (rec.wr) begin
                    mem[mem_addr[31:2]] = mem_wdata;
                    rec.data = mem_wdata;
                end else begin
                    mem_rdata = mem.exists(mem_addr[31:2]) ? mem[mem_addr[31:2]] : 32'hDEAD_BEEF;
                    rec.data  = mem_rdata;
                end
                obs_q.push_back(rec);
            end
        end
    end

    int          checks = 0;
    int          failures = 0;
    int          valid_cycles = 0;
    int          last_base = 0;
    bit          chk_en = 1'b0;
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_reset = 1'b1;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    logic [3:0]  prev_wstrb = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and apply the bus protocol rules to that cycle.
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            if (mem_valid) valid_cycles++;
            if (prev_valid && !prev_ready && !prev_reset && !reset && !err) begin
                chk("hold_valid", 32'(mem_valid), 32'd1);
                chk("hold_addr", mem_addr, prev_addr);
                chk("hold_wstrb", 32'(mem_wstrb), 32'(prev_wstrb));
                chk("hold_wdata", mem_wdata, prev_wdata);
            end
            if (prev_valid && prev_ready && !prev_reset) begin
                chk("drop_after_ready", 32'(mem_valid), 32'd0);
            end
            chk("done_err_excl", 32'(done & err), 32'd0);
        end
        prev_valid = mem_valid;
        prev_ready = mem_ready;
        prev_reset = reset;
        prev_addr  = mem_addr;
        prev_wstrb = mem_wstrb;
        prev_wdata = mem_wdata;
    endtask

    task automatic start_pulse(input logic [31:0] src, input logic [31:0] dst, input int len);
        src_addr  = src;
        dst_addr  = dst;
        len_words = LEN_W'(len);
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill_src(input logic [31:0] src, input int len, input bit pattern);
        logic [31:0] a, d;
        for (int i = 0; i < len; i++) begin
            a = src + 32'(4 * i);
            d = pattern ? 32'hA0 + 32'(i) : $urandom;
            mem[a[31:2]]     = d;
            ref_mem[a[31:2]] = d;
        end
    endtask

    // One full copy checked against the word-by-word reference memory.
    task automatic do_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input bit pattern, input bit poke);
        txn_t        exp_q[$];
        txn_t        t;
        logic [31:0] a, d;
        int          cyc;
        int          base;
        fill_src(src, len, pattern);
        for (int i = 0; i < len; i++) begin
            a = src + 32'(4 * i);
            d = ref_mem[a[31:2]];
            t = '{wr: 1'b0, strb: 4'h0, addr: a, data: d};
            exp_q.push_back(t);
            a = dst + 32'(4 * i);
            ref_mem[a[31:2]] = d;
            t = '{wr: 1'b1, strb: 4'hF, addr: a, data: d};
            exp_q.push_back(t);
        end
        base      = obs_q.size();
        last_base = base;
        start_pulse(src, dst, len);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("words_done_cleared", 32'(words_done), 32'd0);
        cyc = 0;
        while (!(done || err) && cyc < 4000) begin
            start = poke && (cyc == 3);
            if (start) begin
                src_addr  = src + 32'h40;
                dst_addr  = dst + 32'h40;
                len_words = LEN_W'(1);
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("copy_finished", 32'(done | err), 32'd1);
        chk("copy_done", 32'(done), 32'd1);
        chk("copy_no_err", 32'(err), 32'd0);
        chk("copy_busy_low", 32'(busy), 32'd0);
        chk("copy_words_done", 32'(words_done), 32'(len));
        tick();
        chk("done_single_pulse", 32'(done), 32'd0);
        chk("words_done_holds", 32'(words_done), 32'(len));
        chk("txn_count", 32'(obs_q.size() - base), 32'(2 * len));
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            chk("txn_kind", 32'(obs_q[base + i].wr), 32'(exp_q[i].wr));
            chk("txn_wstrb", 32'(obs_q[base + i].strb), 32'(exp_q[i].strb));
            chk("txn_addr", obs_q[base + i].addr, exp_q[i].addr);
            chk("txn_data", obs_q[base + i].data, exp_q[i].data);
        end
        for (int i = 0; i < len; i++) begin
            a = dst + 32'(4 * i);
            chk("dst_written", 32'(mem.exists(a[31:2])), 32'd1);
            if (mem.exists(a[31:2])) chk("dst_data", mem[a[31:2]], ref_mem[a[31:2]]);
        end
    endtask

    initial begin
        int cyc;
        int run;
        int v0;
        int len;
        logic [31:0] s, d;

        reset = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_words_done", 32'(words_done), 32'd0);
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk_en = 1'b1;
        reset  = 1'b0;
        tick();

        // Reference copy with a known data pattern.
        do_copy(32'h100, 32'h200, 4, 1'b1, 1'b0);

        // Zero length finishes immediately without touching the bus.
        v0 = valid_cycles;
        start_pulse(32'h10, 32'h20, 0);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_err", 32'(err), 32'd0);
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_words_done", 32'(words_done), 32'd0);
        repeat (4) tick();
        chk("len0_no_bus", 32'(valid_cycles), 32'(v0));
        chk("len0_done_low", 32'(done), 32'd0);

        // Misaligned source, then misaligned destination.
        start_pulse(32'h102, 32'h200, 4);
        chk("mis_src_err", 32'(err), 32'd1);
        chk("mis_src_done", 32'(done), 32'd0);
        chk("mis_src_busy", 32'(busy), 32'd0);
        tick();
        chk("mis_src_err_low", 32'(err), 32'd0);
        chk("mis_src_busy_low", 32'(busy), 32'd0);
        start_pulse(32'h100, 32'h201, 1);
        chk("mis_dst_err", 32'(err), 32'd1);
        chk("mis_dst_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("mis_no_bus", 32'(valid_cycles), 32'(v0));

        // Ten-cycle stall on every request.
        rand_stall  = 1'b0;
        stall_fixed = 10;
        do_copy(32'h600, 32'h700, 2, 1'b0, 1'b0);
        rand_stall  = 1'b1;

        // Responder hangs on the third word's read: abort after TIMEOUT valid cycles.
        fill_src(32'h800, 3, 1'b0);
        hang_at = obs_q.size() + 4;
        start_pulse(32'h800, 32'h900, 3);
        run = 0;
        cyc = 0;
        while (!err && cyc < 1000) begin
            tick();
            cyc++;
            if (mem_valid) run++;
            else if (!err) run = 0;
        end
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_valid_run", 32'(run), 32'(TIMEOUT));
        chk("tmo_valid_low", 32'(mem_valid), 32'd0);
        chk("tmo_busy_low", 32'(busy), 32'd0);
        chk("tmo_no_done", 32'(done), 32'd0);
        chk("tmo_words_done", 32'(words_done), 32'd2);
        tick();
        chk("tmo_err_single", 32'(err), 32'd0);
        chk("tmo_words_hold", 32'(words_done), 32'd2);
        hang_at = 32'h7fff_ffff;

        // Start pulsed mid-copy must be ignored.
        do_copy(32'hA00, 32'hB00, 3, 1'b0, 1'b1);

        // Source pointer wraps past the top of the address space.
        do_copy(32'hFFFF_FFFC, 32'hC00, 2, 1'b0, 1'b0);
        if (obs_q.size() > last_base + 2) chk("wrap_addr", obs_q[last_base + 2].addr, 32'h0);
        else chk("wrap_txn_present", 32'(obs_q.size()), 32'(last_base + 3));

        for (int k = 0; k < 6; k++) begin
            len = int'($urandom_range(1, 8));
            s   = 32'h1000 + 32'($urandom_range(0, 255)) * 32'd4;
            d   = 32'h2000 + 32'($urandom_range(0, 255)) * 32'd4;
            do_copy(s, d, len, 1'b0, 1'b0);
        end

        // Reset during the second word's write.
        rand_stall  = 1'b0;
        stall_fixed = 5;
        fill_src(32'h400, 3, 1'b0);
        start_pulse(32'h400, 32'h500, 3);
        cyc = 0;
        while (!(mem_valid && mem_wstrb == 4'hF && words_done == LEN_W'(1)) && cyc < 500) begin
            tick();
            cyc++;
        end
        chk("rst_wr_reached", 32'(mem_valid && mem_wstrb == 4'hF && words_done == LEN_W'(1)), 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst_valid", 32'(mem_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_words_done", 32'(words_done), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (3) begin
            tick();
            chk("postrst_no_done", 32'(done), 32'd0);
            chk("postrst_idle", 32'(mem_valid), 32'd0);
        end
        rand_stall = 1'b1;
        do_copy(32'h0, 32'h40, 1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
